// File: rtl/llc_pipe_issue_arb_if.sv
// Requester, issue, retire and flush signals between the LLC input FIFOs,
// the issue arbiter and the mem-read stage.
interface llc_pipe_issue_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int SET_W   = 8,
    parameter int ID_W    = 2,
    parameter int SRC_W   = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*SET_W-1:0] req_set;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [SRC_W-1:0]         issue_src;
    logic [SET_W-1:0]         issue_set;
    logic [ID_W-1:0]          issue_id;
    logic                     retire_valid;
    logic [ID_W-1:0]          retire_id;
    logic                     flush;
    logic [ID_W:0]            inflight_cnt;
    logic                     table_full;

    modport master (
        input  req_valid, req_set, issue_ready,
        input  retire_valid, retire_id, flush,
        output req_ready, issue_valid, issue_src,
        output issue_set, issue_id, inflight_cnt, table_full
    );

    modport slave (
        output req_valid, req_set, issue_ready,
        output retire_valid, retire_id, flush,
        input  req_ready, issue_valid, issue_src,
        input  issue_set, issue_id, inflight_cnt, table_full
    );
endinterface

// File: rtl/llc_pipe_issue_arb.sv
// LLC pipeline issue arbiter: strict-priority responses, round-robin for
// the rest, set-hazard blocking against an in-flight table.
module llc_pipe_issue_arb #(
    parameter int NUM_REQ  = 4,
    parameter int INFLIGHT = 4,
    parameter int SET_W    = 8,
    parameter int ID_W     = $clog2(INFLIGHT),
    parameter int SRC_W    = $clog2(NUM_REQ)
) (
    input logic clk,
    input logic rst,
    llc_pipe_issue_arb_if.master bus
);
    logic [INFLIGHT-1:0] vld;
    logic [SET_W-1:0]    set_q [INFLIGHT];
    logic [SRC_W-1:0]    rr_ptr;
    logic [ID_W:0]       cnt;
    logic                iss_v;
    logic [SRC_W-1:0]    iss_src;
    logic [SET_W-1:0]    iss_set;
    logic [ID_W-1:0]     iss_id;

    logic                any_free;
    logic [ID_W-1:0]     alloc_id;
    logic [NUM_REQ-1:0]  hazard;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  gnt;
    logic                gnt_any;
    logic [SRC_W-1:0]    gnt_src;
    logic [SET_W-1:0]    gnt_set;
    logic                slot_free;
    logic                ret_hit;

    always_comb begin
        any_free = 1'b0;
        alloc_id = '0;
        for (int e = INFLIGHT - 1; e >= 0; e--) begin
            if (!vld[e]) begin
                any_free = 1'b1;
                alloc_id = ID_W'(e);
            end
        end
    end

    // Requester 0 carries responses and never waits on a set hazard
    always_comb begin
        hazard = '0;
        for (int i = 1; i < NUM_REQ; i++) begin
            for (int e = 0; e < INFLIGHT; e++) begin
                if (vld[e] && set_q[e] == bus.req_set[SET_W*i +: SET_W])
                    hazard[i] = 1'b1;
            end
        end
    end

    assign slot_free = !iss_v || bus.issue_ready;
    assign elig = bus.req_valid & ~hazard
                & {NUM_REQ{any_free && slot_free && !bus.flush && rst}};

    always_comb begin
        int               sum;
        logic [SRC_W-1:0] idx;
        gnt_any = 1'b0;
        gnt_src = '0;
        gnt     = '0;
        sum     = 0;
        idx     = '0;
        if (elig[0]) begin
            gnt_any = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                sum = int'(rr_ptr) + k;
                if (sum >= NUM_REQ) sum = sum - (NUM_REQ - 1);
                idx = SRC_W'(sum);
                if (!gnt_any && elig[idx]) begin
                    gnt_any = 1'b1;
                    gnt_src = idx;
                end
            end
        end
        if (gnt_any) gnt[gnt_src] = 1'b1;
    end

    assign gnt_set = bus.req_set[SET_W*int'(gnt_src) +: SET_W];
    assign ret_hit = bus.retire_valid && vld[bus.retire_id];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld     <= '0;
            for (int e = 0; e < INFLIGHT; e++) set_q[e] <= '0;
            rr_ptr  <= SRC_W'(1);
            cnt     <= '0;
            iss_v   <= 1'b0;
            iss_src <= '0;
            iss_set <= '0;
            iss_id  <= '0;
        end else if (bus.flush) begin
            vld   <= '0;
            cnt   <= '0;
            iss_v <= 1'b0;
        end else begin
            // Allocation targets a free entry, so it never collides with a valid retire
            if (bus.retire_valid) vld[bus.retire_id] <= 1'b0;
            if (gnt_any) begin
                vld[alloc_id]   <= 1'b1;
                set_q[alloc_id] <= gnt_set;
            end
            cnt <= cnt + (ID_W+1)'(gnt_any) - (ID_W+1)'(ret_hit);
            if (gnt_any && gnt_src != '0) begin
                rr_ptr <= (int'(gnt_src) == NUM_REQ - 1) ? SRC_W'(1)
                                                         : gnt_src + 1'b1;
            end
            if (gnt_any) begin
                iss_v   <= 1'b1;
                iss_src <= gnt_src;
                iss_set <= gnt_set;
                iss_id  <= alloc_id;
            end else if (bus.issue_ready) begin
                iss_v <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = gnt;
    assign bus.issue_valid  = iss_v;
    assign bus.issue_src    = iss_src;
    assign bus.issue_set    = iss_set;
    assign bus.issue_id     = iss_id;
    assign bus.inflight_cnt = cnt;
    assign bus.table_full   = (cnt == (ID_W+1)'(INFLIGHT));
endmodule

// File: tb/tb_llc_pipe_issue_arb.sv
// Bench for llc_pipe_issue_arb: directed scenarios, issue scoreboard
// popped on every issue handshake.
module tb_llc_pipe_issue_arb;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [11:0] exp_q[$];
    int   t3_src[9] = '{0, 1, 2, 3, 1, 2, 3, 1, 2};

    llc_pipe_issue_arb_if bus ();

    llc_pipe_issue_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input int src, input int set, input int id);
        logic [1:0] s;
        logic [7:0] st;
        logic [1:0] d;
        s  = src[1:0];
        st = set[7:0];
        d  = id[1:0];
        exp_q.push_back({s, st, d});
    endtask

    task automatic set_req(input int i, input logic [7:0] s);
        bus.req_set[8*i +: 8] = s;
    endtask

    task automatic idle_in();
        bus.req_valid    = '0;
        bus.retire_valid = 1'b0;
        bus.retire_id    = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_in();
        bus.issue_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Scoreboard: every accepted issue must match the oldest expectation
    always @(negedge clk) begin
        #4;
        if (rst && bus.issue_valid && bus.issue_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", {20'd0, bus.issue_src, bus.issue_set, bus.issue_id}, 32'hFFF);
            end else begin
                chk("sb_issue", {20'd0, bus.issue_src, bus.issue_set, bus.issue_id},
                    {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.req_set = '0;
        bus.issue_ready = 1'b1;
        idle_in();
        #1 rst = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_ivalid", bus.issue_valid, 0);
        chk("rst_cnt", bus.inflight_cnt, 0);
        chk("rst_full", bus.table_full, 0);
        @(negedge clk);
        idle_in();
        rst = 1'b1;

        // 1: single request from requester 1
        @(negedge clk);
        bus.req_valid = 4'b0010;
        set_req(1, 8'h12);
        #1 chk("t1_ready", bus.req_ready, 4'b0010);
        push_exp(1, 'h12, 0);
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk("t1_ivalid", bus.issue_valid, 1);
        chk("t1_cnt", bus.inflight_cnt, 1);

        // 2: set hazard against in-flight 0x12
        @(negedge clk);
        bus.req_valid = 4'b0100;
        set_req(2, 8'h12);
        #1 chk("t2_haz0", bus.req_ready, 0);
        @(negedge clk);
        #1 chk("t2_haz1", bus.req_ready, 0);
        @(negedge clk);
        bus.retire_valid = 1'b1;
        bus.retire_id = 2'd0;
        #1 chk("t2_haz_ret", bus.req_ready, 0);
        @(negedge clk);
        bus.retire_valid = 1'b0;
        #1 chk("t2_grant", bus.req_ready, 4'b0100);
        chk("t2_cnt0", bus.inflight_cnt, 0);
        push_exp(2, 'h12, 0);
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk("t2_cnt1", bus.inflight_cnt, 1);

        // 3: round-robin order with immediate retire
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'h30 + 8'(i));
        for (int c = 0; c < 9; c++) push_exp(t3_src[c], 'h30 + t3_src[c], c % 2);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bus.req_valid = (c == 0) ? 4'b1111 : 4'b1110;
            bus.retire_valid = bus.issue_valid;
            bus.retire_id = bus.issue_id;
            #1 chk("t3_ready", bus.req_ready, 32'd1 << t3_src[c]);
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.retire_valid = bus.issue_valid;
        bus.retire_id = bus.issue_id;
        @(negedge clk);
        bus.retire_valid = 1'b0;
        #1 chk("t3_cnt", bus.inflight_cnt, 0);

        // 4: full table, retire id2 frees the slot for the waiter
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.req_valid = 4'b0010;
            set_req(1, 8'h40 + 8'(c));
            push_exp(1, 'h40 + c, c);
        end
        @(negedge clk);
        bus.req_valid = 4'b0100;
        set_req(2, 8'h50);
        #1 chk("t4_cnt4", bus.inflight_cnt, 4);
        chk("t4_full", bus.table_full, 1);
        chk("t4_wait0", bus.req_ready, 0);
        @(negedge clk);
        bus.retire_valid = 1'b1;
        bus.retire_id = 2'd2;
        #1 chk("t4_wait_ret", bus.req_ready, 0);
        @(negedge clk);
        bus.retire_valid = 1'b0;
        #1 chk("t4_cnt3", bus.inflight_cnt, 3);
        chk("t4_grant", bus.req_ready, 4'b0100);
        push_exp(2, 'h50, 2);
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk("t4_cnt4b", bus.inflight_cnt, 4);
        chk("t4_full_b", bus.table_full, 1);

        // 5: backpressure holds the issue slot stable
        do_reset();
        @(negedge clk);
        bus.issue_ready = 1'b0;
        bus.req_valid = 4'b0010;
        set_req(1, 8'h60);
        push_exp(1, 'h60, 0);
        @(negedge clk);
        set_req(1, 8'h61);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1 chk("t5_ready", bus.req_ready, 0);
            chk("t5_stable", {bus.issue_valid, bus.issue_src, bus.issue_set, bus.issue_id},
                {1'b1, 2'd1, 8'h60, 2'd0});
        end
        @(negedge clk);
        bus.issue_ready = 1'b1;
        #1 chk("t5_grant", bus.req_ready, 4'b0010);
        push_exp(1, 'h61, 1);
        @(negedge clk);
        bus.req_valid = '0;

        // 6: flush with same-cycle retire, then hazard waiter proceeds
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b0010;
        set_req(1, 8'h70);
        push_exp(1, 'h70, 0);
        @(negedge clk);
        set_req(1, 8'h71);
        push_exp(1, 'h71, 1);
        @(negedge clk);
        set_req(1, 8'h72);
        @(negedge clk);
        bus.issue_ready = 1'b0;
        bus.req_valid = 4'b0100;
        set_req(2, 8'h70);
        #1 chk("t6_cnt3", bus.inflight_cnt, 3);
        chk("t6_haz", bus.req_ready, 0);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.retire_valid = 1'b1;
        bus.retire_id = 2'd0;
        #1 chk("t6_flush_rdy", bus.req_ready, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.retire_valid = 1'b0;
        #1 chk("t6_ivalid", bus.issue_valid, 0);
        chk("t6_cnt0", bus.inflight_cnt, 0);
        chk("t6_full", bus.table_full, 0);
        chk("t6_grant", bus.req_ready, 4'b0100);
        push_exp(2, 'h70, 0);
        @(negedge clk);
        bus.req_valid = '0;
        bus.issue_ready = 1'b1;

        // 7: asynchronous reset mid-operation
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.req_valid = 4'b0010;
            set_req(1, 8'h80 + 8'(c));
            if (c < 2) push_exp(1, 'h80 + c, c);
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.issue_ready = 1'b0;
        #1 chk("t7_cnt3", bus.inflight_cnt, 3);
        chk("t7_ivalid", bus.issue_valid, 1);
        bus.issue_ready = 1'b1;
        bus.req_valid = 4'b0010;
        set_req(1, 8'h90);
        #1 rst = 1'b0;
        #1 chk("t7_rst_out", {bus.issue_valid, bus.issue_src, bus.issue_set, bus.issue_id},
               0);
        chk("t7_rst_cnt", bus.inflight_cnt, 0);
        chk("t7_rst_full", bus.table_full, 0);
        chk("t7_rst_ready", bus.req_ready, 0);
        @(negedge clk);
        idle_in();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("sb_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
